api_pll_sched: RTL
==================

Name: api_pll_sched

Overview:
- Scheduler/feeder for the PLL-configuration path of the API chain controller.
- The CPU stages 96-bit PLL words plus a {chip, miner} target through a small register port. Staged entries are queued in a show-ahead FIFO and presented to the chain controller as pllf_dout / reg_pllf_empty.
- The controller consumes one 32-bit word per pllf_rd_en pulse. The block retires an entry after three pulses.
- Entries whose target never appears are dropped after a configurable number of load rotations.

Parameters:
- DEPTH, 4: number of queued PLL entries; power of 2, minimum 2.
- MAX_ROUNDS, 12: full load rotations an unconsumed head entry survives before it is dropped.
- ROUND_LEN, 10: number of load advances per full rotation (equals API_NUM).

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous reset, active-high.
- reg_rst, input, 1: synchronous soft reset; same effect as rst.
- cfg_wr_en, input, 1: CPU write strobe, one cycle.
- cfg_wr_addr, input, 2: 0/1/2 selects staging word 0/1/2; 3 selects commit.
- cfg_wr_data, input, 32: staging data. On commit, bits [7:4] = chip and bits [3:0] = miner.
- load_adv, input, 1: one-cycle pulse each time the chain controller advances load.
- pllf_rd_en, input, 1: one-cycle pulse per PLL word consumed.
- pllf_dout, output, 104: head entry {w2, w1, w0, chip, miner}.
- reg_pllf_empty, output, 1: FIFO empty.
- cfg_full, output, 1: FIFO holds DEPTH entries.
- cfg_ovf, output, 1: sticky flag; a commit was attempted while full.
- done_cnt, output, 8: count of entries fully consumed; wraps.
- drop_cnt, output, 8: count of entries dropped by timeout; wraps.

Behaviour:
- Reset (rst or reg_rst):
  - FIFO emptied; staging registers set to 0.
  - word_idx, adv_cnt and round_cnt set to 0.
  - Outputs: reg_pllf_empty=1, cfg_full=0, cfg_ovf=0, done_cnt=0, drop_cnt=0, pllf_dout=0.
- Staging writes (addr 0..2):
  - Load the selected 32-bit staging word on the next edge.
  - No effect on the FIFO.
- Commit (addr 3):
  - Pushes {w2, w1, w0, data[7:4], data[3:0]} on the next edge.
  - If full: no push, cfg_ovf is set, and the entry is lost.
  - Staging words are retained, so a repeat commit reuses them.
- Output timing:
  - Show-ahead FIFO: pllf_dout is valid whenever reg_pllf_empty=0.
  - The first entry is visible the cycle after the commit edge.
- Consumption:
  - word_idx (2 bits) counts pllf_rd_en pulses while not empty.
  - On the third pulse (word_idx==2): pop the head, word_idx returns to 0, done_cnt increments.
  - pllf_rd_en while empty is ignored.
- Simultaneous push and pop: both take effect; occupancy is unchanged.
  - A commit while full in the same cycle as the final pop succeeds; no overflow is flagged.
- Round tracking:
  - adv_cnt counts load_adv pulses from 0 to ROUND_LEN-1 and wraps.
  - On wrap, round_cnt increments if the FIFO is non-empty.
  - adv_cnt and round_cnt clear on every pop and whenever the FIFO is empty.
- Drop rule:
  - Condition: round_cnt==MAX_ROUNDS, word_idx==0, and no pllf_rd_en in that cycle.
  - Effect: the head is popped and drop_cnt increments.
  - If word_idx≠0 (partially consumed), the entry is never dropped; it waits for the remaining pulses.
  - If pllf_rd_en and the drop condition coincide, the consume path wins.
- Widths: done_cnt and drop_cnt wrap 255→0 with no saturation.
- Reset mid-entry (word_idx 1 or 2): the entry is discarded and is not counted as done or dropped.

Decomposition:
- Shared package api_define:
  - PLLF_W=104.
  - PLL_WORDS=3.
  - Field offsets MINER_LSB=0, CHIP_LSB=4, W0_LSB=8, W1_LSB=40, W2_LSB=72.
  - Commit address constant CFG_COMMIT=2'd3.
- One sub-module, api_pllf_fifo:
  - Synchronous show-ahead FIFO, width PLLF_W, depth DEPTH.
  - Provides full/empty and supports simultaneous push and pop.

Test Plan:
- Stage w0=0x11111111, w1=0x22222222, w2=0x33333333, commit data=0x25 → pllf_dout=0x333333332222222211111111_25, reg_pllf_empty=0 one cycle after the commit.
- Same entry, then three pllf_rd_en pulses → still non-empty after pulses 1 and 2; after pulse 3 reg_pllf_empty=1 and done_cnt=1.
- Five commits with DEPTH=4 → cfg_full=1 after the 4th commit; cfg_ovf=1 after the 5th; a later drain yields exactly 4 entries and done_cnt=4.
- One entry, no rd_en, load_adv pulsed 120 times (12×10) → entry dropped, drop_cnt=1, reg_pllf_empty=1; at 119 pulses the entry is still present.
- One pllf_rd_en pulse, then 200 load_adv pulses → no drop (word_idx=1); two further pulses → done_cnt=1.
- Assert reg_rst after two rd_en pulses with 3 entries queued → reg_pllf_empty=1, all counters 0, cfg_ovf=0 on the next cycle.

Source files
------------

// File: rtl/api_pll_sched_pkg.sv
// Shared types and field layout for the PLL-configuration scheduler.
// An entry packs three 32-bit PLL words above an 8-bit {chip, miner} target.
package api_define;

    localparam int PLLF_W    = 104;
    localparam int PLL_WORDS = 3;
    localparam int MINER_LSB = 0;
    localparam int CHIP_LSB  = 4;
    localparam int W0_LSB    = 8;
    localparam int W1_LSB    = 40;
    localparam int W2_LSB    = 72;

    localparam logic [1:0] CFG_COMMIT = 2'd3;

    typedef logic [PLLF_W-1:0] pllf_t;
    typedef logic [PLL_WORDS-1:0][31:0] stage_t;

    function automatic pllf_t pack_entry(
        input stage_t     w,
        input logic [7:0] tgt
    );
        pllf_t e;
        e = '0;
        e[W2_LSB +: 32]   = w[2];
        e[W1_LSB +: 32]   = w[1];
        e[W0_LSB +: 32]   = w[0];
        e[CHIP_LSB +: 4]  = tgt[7:4];
        e[MINER_LSB +: 4] = tgt[3:0];
        return e;
    endfunction

endpackage

// File: rtl/api_pll_sched_if.sv
// CPU staging port plus the chain-controller PLL feed.
// master = CPU/controller side, slave = scheduler.
interface api_pll_sched_if;
    import api_define::*;

    logic              cfg_wr_en;
    logic [1:0]        cfg_wr_addr;
    logic [31:0]       cfg_wr_data;
    logic              load_adv;
    logic              pllf_rd_en;
    logic [PLLF_W-1:0] pllf_dout;
    logic              reg_pllf_empty;
    logic              cfg_full;
    logic              cfg_ovf;
    logic [7:0]        done_cnt;
    logic [7:0]        drop_cnt;

    modport master (
        output cfg_wr_en, cfg_wr_addr, cfg_wr_data,
        output load_adv, pllf_rd_en,
        input  pllf_dout, reg_pllf_empty,
        input  cfg_full, cfg_ovf,
        input  done_cnt, drop_cnt
    );

    modport slave (
        input  cfg_wr_en, cfg_wr_addr, cfg_wr_data,
        input  load_adv, pllf_rd_en,
        output pllf_dout, reg_pllf_empty,
        output cfg_full, cfg_ovf,
        output done_cnt, drop_cnt
    );

endinterface

// File: rtl/api_pllf_fifo.sv
// Show-ahead FIFO for PLL entries; head is visible whenever not empty.
// Callers must not push when full (unless popping) nor pop when empty.
module api_pllf_fifo #(
    parameter int W     = 104,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wp_q;
    logic [PW-1:0] rp_q;
    logic [PW:0]   cnt_q;

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wp_q] <= din_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wp_q <= wp_q + 1'b1;
            if (pop_i)  rp_q <= rp_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    // Empty reads as zero so the feed is clean after reset.
    assign dout_o  = empty_o ? '0 : mem_q[rp_q];

endmodule

// File: rtl/api_pll_sched.sv
// PLL-configuration scheduler: stages CPU words, queues entries, feeds
// the chain controller three words at a time and drops stale heads.
module api_pll_sched
    import api_define::*;
#(
    parameter int DEPTH      = 4,
    parameter int MAX_ROUNDS = 12,
    parameter int ROUND_LEN  = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            reg_rst,
    api_pll_sched_if.slave  bus
);

    localparam int AW = $clog2(ROUND_LEN);
    localparam int RW = $clog2(MAX_ROUNDS + 1);

    stage_t        stg_q, stg_d;
    logic [1:0]    widx_q, widx_d;
    logic [AW-1:0] adv_q, adv_d;
    logic [RW-1:0] rnd_q, rnd_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    done_q, done_d;
    logic [7:0]    drop_q, drop_d;

    logic  f_empty, f_full;
    pllf_t f_dout;
    pllf_t entry;
    logic  commit, rd_ok, cons, drop, pop, push;

    always_comb begin
        commit = bus.cfg_wr_en && (bus.cfg_wr_addr == CFG_COMMIT);
        rd_ok  = bus.pllf_rd_en && !f_empty;
        cons   = rd_ok && (widx_q == 2'd2);
        // A partially read head is never dropped; read pulses win.
        drop   = !f_empty && !bus.pllf_rd_en && (widx_q == 2'd0)
                 && (rnd_q == RW'(MAX_ROUNDS));
        pop    = cons || drop;
        push   = commit && (!f_full || pop);
        entry  = pack_entry(stg_q, bus.cfg_wr_data[7:0]);
    end

    always_comb begin
        stg_d  = stg_q;
        widx_d = widx_q;
        adv_d  = adv_q;
        rnd_d  = rnd_q;
        ovf_d  = ovf_q;
        done_d = done_q;
        drop_d = drop_q;

        if (bus.cfg_wr_en) begin
            case (bus.cfg_wr_addr)
                2'd0:    stg_d[0] = bus.cfg_wr_data;
                2'd1:    stg_d[1] = bus.cfg_wr_data;
                2'd2:    stg_d[2] = bus.cfg_wr_data;
                default: stg_d    = stg_q;
            endcase
        end

        if (commit && !push) ovf_d = 1'b1;

        if (rd_ok) widx_d = cons ? 2'd0 : widx_q + 2'd1;

        if (cons) done_d = done_q + 8'd1;
        if (drop) drop_d = drop_q + 8'd1;

        // Rotation age belongs to the current head only.
        if (f_empty || pop) begin
            adv_d = '0;
            rnd_d = '0;
        end else if (bus.load_adv) begin
            if (adv_q == AW'(ROUND_LEN - 1)) begin
                adv_d = '0;
                if (rnd_q != RW'(MAX_ROUNDS)) rnd_d = rnd_q + 1'b1;
            end else begin
                adv_d = adv_q + 1'b1;
            end
        end

        if (reg_rst) begin
            stg_d  = '0;
            widx_d = '0;
            adv_d  = '0;
            rnd_d  = '0;
            ovf_d  = 1'b0;
            done_d = '0;
            drop_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_q  <= '0;
            widx_q <= '0;
            adv_q  <= '0;
            rnd_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= '0;
            drop_q <= '0;
        end else begin
            stg_q  <= stg_d;
            widx_q <= widx_d;
            adv_q  <= adv_d;
            rnd_q  <= rnd_d;
            ovf_q  <= ovf_d;
            done_q <= done_d;
            drop_q <= drop_d;
        end
    end

    api_pllf_fifo #(
        .W     (PLLF_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (reg_rst),
        .push_i  (push),
        .din_i   (entry),
        .pop_i   (pop),
        .dout_o  (f_dout),
        .empty_o (f_empty),
        .full_o  (f_full)
    );

    assign bus.pllf_dout      = f_dout;
    assign bus.reg_pllf_empty = f_empty;
    assign bus.cfg_full       = f_full;
    assign bus.cfg_ovf        = ovf_q;
    assign bus.done_cnt       = done_q;
    assign bus.drop_cnt       = drop_q;

endmodule
